// File: rtl/store_pkg.sv
// Shared types and item classification equations for the store exit gate.
// STORE_GUARD_ACK_EN adds the WAIT_ACK state (alarm latched until guard acknowledge).
package store_pkg;

   localparam int CODE_W = 4;

`ifdef STORE_GUARD_ACK_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_PASS,
      ST_ALARM,
      ST_WAIT_ACK
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_PASS,
      ST_ALARM
   } state_t;
`endif

   function automatic logic is_stolen(input logic [CODE_W-1:0] c);
      return (c[0] & ~c[1] & ~c[3]) | (~c[0] & ~c[2] & ~c[3]);
   endfunction

   function automatic logic is_discount(input logic [CODE_W-1:0] c);
      return c[1] | (c[0] & c[2]);
   endfunction

endpackage

// File: rtl/store_item_classifier.sv
// Combinational stolen/discount decode of a registered item code.
module store_item_classifier
   import store_pkg::*;
(
   input  logic [CODE_W-1:0] code,
   output logic              stolen,
   output logic              discount
);

   assign stolen   = is_stolen(code);
   assign discount = is_discount(code);

endmodule

// File: rtl/store_exit_controller.sv
// Exit gate sequencer: accepts one scanned item, opens the gate or raises the alarm, keeps tallies.
// STORE_GUARD_ACK_EN holds the alarm in WAIT_ACK until guard_ack.
//
// state       | meaning
// ST_IDLE     | item_ready=1, waiting for a scanned item
// ST_CHECK    | one cycle: classify registered code, bump tallies, load timer
// ST_PASS     | gate_open=1 for PASS_CYCLES cycles
// ST_ALARM    | alarm=1 for ALARM_CYCLES cycles
// ST_WAIT_ACK | alarm held until guard_ack (STORE_GUARD_ACK_EN only)
module store_exit_controller
   import store_pkg::*;
#(
   parameter int PASS_CYCLES  = 4,
   parameter int ALARM_CYCLES = 16,
   parameter int CNT_W        = 8
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              item_valid,
   output logic              item_ready,
   input  logic [CODE_W-1:0] item_code,
   input  logic              clear_counts,
   input  logic              guard_ack,
   output logic              gate_open,
   output logic              alarm,
   output logic              disc_led,
   output logic [CNT_W-1:0]  item_count,
   output logic [CNT_W-1:0]  stolen_count,
   output logic [CNT_W-1:0]  disc_count
);

   localparam int T_MAX   = (PASS_CYCLES > ALARM_CYCLES) ? PASS_CYCLES : ALARM_CYCLES;
   localparam int TIMER_W = $clog2(T_MAX) + 1;
   localparam logic [TIMER_W-1:0] PASS_LOAD  = TIMER_W'(PASS_CYCLES - 1);
   localparam logic [TIMER_W-1:0] ALARM_LOAD = TIMER_W'(ALARM_CYCLES - 1);

   state_t              state;
   logic [TIMER_W-1:0]  timer;
   logic [CODE_W-1:0]   code_q;
   logic                stolen;
   logic                discount;

`ifndef STORE_GUARD_ACK_EN
   logic unused_guard_ack;
   assign unused_guard_ack = guard_ack;
`endif

   store_item_classifier u_classifier (
      .code     (code_q),
      .stolen   (stolen),
      .discount (discount)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         timer        <= '0;
         code_q       <= '0;
         item_ready   <= 1'b1;
         gate_open    <= 1'b0;
         alarm        <= 1'b0;
         disc_led     <= 1'b0;
         item_count   <= '0;
         stolen_count <= '0;
         disc_count   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (item_valid && item_ready) begin
                  code_q     <= item_code;
                  item_ready <= 1'b0;
                  state      <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (item_count != '1) item_count <= item_count + 1'b1;
               if (stolen) begin
                  if (stolen_count != '1) stolen_count <= stolen_count + 1'b1;
                  alarm <= 1'b1;
                  timer <= ALARM_LOAD;
                  state <= ST_ALARM;
               end else begin
                  disc_led <= discount;
                  if (discount && disc_count != '1) disc_count <= disc_count + 1'b1;
                  gate_open <= 1'b1;
                  timer     <= PASS_LOAD;
                  state     <= ST_PASS;
               end
            end
            ST_PASS: begin
               if (timer == '0) begin
                  gate_open  <= 1'b0;
                  item_ready <= 1'b1;
                  state      <= ST_IDLE;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            ST_ALARM: begin
               if (timer == '0) begin
`ifdef STORE_GUARD_ACK_EN
                  state <= ST_WAIT_ACK;
`else
                  alarm      <= 1'b0;
                  item_ready <= 1'b1;
                  state      <= ST_IDLE;
`endif
               end else begin
                  timer <= timer - 1'b1;
               end
            end
`ifdef STORE_GUARD_ACK_EN
            ST_WAIT_ACK: begin
               if (guard_ack) begin
                  alarm      <= 1'b0;
                  item_ready <= 1'b1;
                  state      <= ST_IDLE;
               end
            end
`endif
            default: begin
               gate_open  <= 1'b0;
               alarm      <= 1'b0;
               item_ready <= 1'b1;
               state      <= ST_IDLE;
            end
         endcase

         // Clear is placed last so it overrides any increment from CHECK.
         if (clear_counts) begin
            item_count   <= '0;
            stolen_count <= '0;
            disc_count   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_store_exit_controller.sv
// Directed bench for store_exit_controller: item table plus reset, clear and guard-ack sequences.
module tb_store_exit_controller;

   localparam int PASS_C  = 4;
   localparam int ALARM_C = 16;
   localparam int CW      = 2;
   localparam int SAT     = 3;
   localparam int WIN     = 20;
`ifdef STORE_GUARD_ACK_EN
   localparam int ACK_X = 1;
`else
   localparam int ACK_X = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          item_valid;
   logic          item_ready;
   logic [3:0]    item_code;
   logic          clear_counts;
   logic          guard_ack;
   logic          gate_open;
   logic          alarm;
   logic          disc_led;
   logic [CW-1:0] item_count;
   logic [CW-1:0] stolen_count;
   logic [CW-1:0] disc_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   store_exit_controller #(
      .PASS_CYCLES  (PASS_C),
      .ALARM_CYCLES (ALARM_C),
      .CNT_W        (CW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .item_valid   (item_valid),
      .item_ready   (item_ready),
      .item_code    (item_code),
      .clear_counts (clear_counts),
      .guard_ack    (guard_ack),
      .gate_open    (gate_open),
      .alarm        (alarm),
      .disc_led     (disc_led),
      .item_count   (item_count),
      .stolen_count (stolen_count),
      .disc_count   (disc_count)
   );

   typedef struct {
      logic [3:0] code;
      bit         stolen;
      bit         disc;
      bit         led;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] win(input int lo, input int hi);
      logic [31:0] m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic int sat_inc(input int v);
      return (v < SAT) ? v + 1 : v;
   endfunction

   // Offers one item at a negedge; bit k of g/a/r is the value sampled k cycles after acceptance.
   task automatic run_item(input logic [3:0] code, input int len,
                           output logic [31:0] g, output logic [31:0] a, output logic [31:0] r);
      int w;
      g = '0; a = '0; r = '0;
      w = 0;
      while (!item_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("ready_before_item", item_ready, 1);
      item_code  = code;
      item_valid = 1'b1;
      @(negedge clk);
      item_valid = 1'b0;
      for (int k = 1; k <= len; k++) begin
         if (k > 1) @(negedge clk);
         g[k] = gate_open;
         a[k] = alarm;
         r[k] = item_ready;
      end
   endtask

   initial begin
      logic [31:0] g, a, r;
      int m_item, m_stol, m_disc, aend, w;

      tbl[0] = '{4'b0011, 1'b0, 1'b1, 1'b1};
      tbl[1] = '{4'b1000, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{4'b0001, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{4'b1101, 1'b0, 1'b1, 1'b1};
      tbl[4] = '{4'b0000, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{4'b0110, 1'b0, 1'b1, 1'b1};

      reset = 1'b1; item_valid = 1'b0; item_code = '0;
      clear_counts = 1'b0; guard_ack = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset mid-ALARM
      item_code = 4'b0001; item_valid = 1'b1;
      @(negedge clk);
      item_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("alarm_before_reset", alarm, 1);
      chk("stolen_before_reset", stolen_count, 1);
      reset = 1'b1;
      #1;
      chk("rst_alarm", alarm, 0);
      chk("rst_ready", item_ready, 1);
      chk("rst_gate", gate_open, 0);
      chk("rst_item_count", item_count, 0);
      chk("rst_stolen_count", stolen_count, 0);
      chk("rst_disc_count", disc_count, 0);
      chk("rst_disc_led", disc_led, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Item table; guard_ack held high so the acknowledged build also returns to IDLE
      m_item = 0; m_stol = 0; m_disc = 0;
      guard_ack = 1'b1;
      foreach (tbl[i]) begin
         run_item(tbl[i].code, WIN, g, a, r);
         m_item = sat_inc(m_item);
         if (tbl[i].stolen) m_stol = sat_inc(m_stol);
         else if (tbl[i].disc) m_disc = sat_inc(m_disc);
         aend = tbl[i].stolen ? 1 + ALARM_C + ACK_X : 1 + PASS_C;
         chk($sformatf("gate_window[%0d]", i), g, tbl[i].stolen ? 32'h0 : win(2, 1 + PASS_C));
         chk($sformatf("alarm_window[%0d]", i), a, tbl[i].stolen ? win(2, aend) : 32'h0);
         chk($sformatf("ready_window[%0d]", i), r, win(aend + 1, WIN));
         chk($sformatf("disc_led[%0d]", i), disc_led, tbl[i].led);
         chk($sformatf("item_count[%0d]", i), item_count, m_item);
         chk($sformatf("stolen_count[%0d]", i), stolen_count, m_stol);
         chk($sformatf("disc_count[%0d]", i), disc_count, m_disc);
      end
      guard_ack = 1'b0;

      // Clear asserted in the CHECK cycle of a discounted item
      item_code = 4'b0110; item_valid = 1'b1;
      @(negedge clk);
      item_valid   = 1'b0;
      clear_counts = 1'b1;
      chk("item_count_saturated", item_count, SAT);
      @(negedge clk);
      clear_counts = 1'b0;
      chk("clr_item_count", item_count, 0);
      chk("clr_stolen_count", stolen_count, 0);
      chk("clr_disc_count", disc_count, 0);
      chk("clr_gate_open", gate_open, 1);
      chk("clr_disc_led_kept", disc_led, 1);
      w = 0;
      while (!item_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("clr_back_to_idle", item_ready, 1);

      // Guard acknowledge: guard_ack stays low 10 cycles past the timer, then pulses
      run_item(4'b0000, 28, g, a, r);
      guard_ack = 1'b1;
      @(negedge clk);
      guard_ack = 1'b0;
`ifdef STORE_GUARD_ACK_EN
      chk("ack_alarm_window", a, win(2, 28));
      chk("ack_ready_window", r, 32'h0);
`else
      chk("ack_alarm_window", a, win(2, 1 + ALARM_C));
      chk("ack_ready_window", r, win(2 + ALARM_C, 28));
`endif
      chk("ack_alarm_after", alarm, 0);
      chk("ack_ready_after", item_ready, 1);
      chk("ack_gate_window", g, 32'h0);
      chk("ack_stolen_count", stolen_count, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
